// File: rtl/pool_upsample2x_if.sv
// ---------------------------------------------------------------------------
// pool_upsample2x_if
// Stream bundle for the 2x nearest-neighbour unpooling stage.
//   in_data/in_valid/in_ready : pooled pixel input (valid/ready)
//   out_data/out_valid/out_ready : upsampled pixel output (valid/ready)
//   out_row_phase : 0 = live copy of a row, 1 = replayed copy
//   out_last      : final beat of each output row
//   frame_done    : one-cycle pulse after the last beat of a frame
// The master modport is the environment (drives inputs, consumes outputs).
// The slave modport is the upsampler itself.
// ---------------------------------------------------------------------------
interface pool_upsample2x_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_row_phase;
    logic                  out_last;
    logic                  frame_done;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_row_phase, out_last, frame_done
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_row_phase, out_last, frame_done
    );
endinterface

// File: rtl/pool_upsample2x.sv
// ---------------------------------------------------------------------------
// pool_upsample2x
// 2x nearest-neighbour unpooling. Each pooled pixel is emitted twice
// horizontally; each row is emitted twice vertically, the second copy being
// replayed from a one-row register line buffer. Output frame is
// 2*WIDTH_IN x 2*HEIGHT_IN.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   up    : stream bundle (slave side), see pool_upsample2x_if
// ---------------------------------------------------------------------------
module pool_upsample2x #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH_IN   = 13,
    parameter int HEIGHT_IN  = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    pool_upsample2x_if.slave  up
);
    localparam int CW = $clog2(WIDTH_IN + 1);
    localparam int RW = (HEIGHT_IN > 1) ? $clog2(HEIGHT_IN) : 1;
    localparam int IW = (WIDTH_IN > 1) ? $clog2(WIDTH_IN) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH_IN - 1);
    localparam logic [CW-1:0] COL_END  = CW'(WIDTH_IN);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_IN - 1);

    typedef enum logic {
        LIVE   = 1'b0,
        REPEAT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         in_cnt_q, in_cnt_d;
    logic [CW-1:0]         rep_col_q, rep_col_d;
    logic [RW-1:0]         row_q, row_d;
    logic                  dup_q, dup_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_done_q, frame_done_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    // Line buffer: holds the live row so it can be replayed; never reset.
    logic [DATA_WIDTH-1:0] line_q [WIDTH_IN];

    logic                  in_ready;
    logic                  accept;
    logic                  beat;
    logic                  row_end;
    logic [CW-1:0]         out_col;
    logic [CW-1:0]         rep_nxt;
    logic [IW-1:0]         wr_idx;

    // In LIVE the pixel on the output was written at in_cnt-1 (counter has
    // already advanced past it); in REPEAT the replay column is explicit.
    assign out_col = (state_q == LIVE) ? (in_cnt_q - CW'(1)) : rep_col_q;
    assign rep_nxt = rep_col_q + CW'(1);
    assign wr_idx  = in_cnt_q[IW-1:0];

    // Second copy of the last pixel in the current output row.
    assign row_end = out_valid_q & dup_q & (out_col == COL_LAST);

    assign accept  = up.in_valid & in_ready;
    assign beat    = out_valid_q & up.out_ready;

    // in_ready is forced low while reset is asserted so that every output
    // reads zero during reset, not just the registered ones.
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            if (state_q == LIVE) begin
                in_ready = (in_cnt_q < COL_END) & (!out_valid_q | (dup_q & up.out_ready));
            end else begin
                in_ready = row_end & up.out_ready & (row_q != ROW_LAST);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        in_cnt_d     = in_cnt_q;
        rep_col_d    = rep_col_q;
        row_d        = row_q;
        dup_d        = dup_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;

        if (state_q == LIVE) begin
            if (beat) begin
                if (!dup_q) begin
                    dup_d = 1'b1;
                end else if (row_end) begin
                    // Start the replay immediately: no bubble between copies.
                    state_d     = REPEAT;
                    out_data_d  = line_q[0];
                    dup_d       = 1'b0;
                    out_valid_d = 1'b1;
                    in_cnt_d    = '0;
                    rep_col_d   = '0;
                end else if (!accept) begin
                    out_valid_d = 1'b0;
                end
            end
            if (accept) begin
                out_data_d  = up.in_data;
                out_valid_d = 1'b1;
                dup_d       = 1'b0;
                in_cnt_d    = in_cnt_q + CW'(1);
            end
        end else begin
            if (beat) begin
                if (!dup_q) begin
                    dup_d = 1'b1;
                end else if (!row_end) begin
                    rep_col_d  = rep_nxt;
                    out_data_d = line_q[rep_nxt[IW-1:0]];
                    dup_d      = 1'b0;
                end else if (row_q != ROW_LAST) begin
                    row_d   = row_q + RW'(1);
                    state_d = LIVE;
                    if (accept) begin
                        // First pixel of the next row overlaps the last replay beat.
                        out_data_d  = up.in_data;
                        out_valid_d = 1'b1;
                        dup_d       = 1'b0;
                        in_cnt_d    = in_cnt_q + CW'(1);
                    end else begin
                        out_valid_d = 1'b0;
                    end
                end else begin
                    frame_done_d = 1'b1;
                    row_d        = '0;
                    state_d      = LIVE;
                    out_valid_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LIVE;
            in_cnt_q     <= '0;
            rep_col_q    <= '0;
            row_q        <= '0;
            dup_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            rep_col_q    <= rep_col_d;
            row_q        <= row_d;
            dup_q        <= dup_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            line_q[wr_idx] <= up.in_data;
        end
    end

    assign up.in_ready      = in_ready;
    assign up.out_data      = out_data_q;
    assign up.out_valid     = out_valid_q;
    assign up.out_row_phase = (state_q == REPEAT);
    assign up.out_last      = row_end;
    assign up.frame_done    = frame_done_q;
endmodule

// File: tb/tb_pool_upsample2x.sv
// ---------------------------------------------------------------------------
// tb_pool_upsample2x
// Bench for pool_upsample2x: a 13x13 instance driven by directed vectors and
// by ramp/random frames checked against a beat-index reference model, plus a
// 1x1 instance driven by directed vectors.
// ---------------------------------------------------------------------------
module tb_pool_upsample2x;
    localparam int DW = 8;
    localparam int W  = 13;
    localparam int H  = 13;
    localparam int FB = 4 * W * H;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pool_upsample2x_if #(.DATA_WIDTH(DW)) ifa ();
    pool_upsample2x_if #(.DATA_WIDTH(DW)) ifb ();

    pool_upsample2x #(.DATA_WIDTH(DW), .WIDTH_IN(W), .HEIGHT_IN(H)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (ifa)
    );

    pool_upsample2x #(.DATA_WIDTH(DW), .WIDTH_IN(1), .HEIGHT_IN(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .up    (ifb)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Directed per-cycle vectors: sel picks the 13x13 (0) or 1x1 (1) instance.
    typedef struct {
        bit       sel;
        bit       iv;
        bit [7:0] d;
        bit       orr;
        bit       ov;
        bit [7:0] od;
        bit       ir;
        bit       ph;
        bit       lst;
        bit       fd;
    } vec_t;

    vec_t tv[13];

    // Reference model state: output beat n of a frame is fully determined by
    // the pixels accepted in that frame and simple index arithmetic.
    logic [7:0] pix[W*H];
    int   n_acc, n_beat, fd_cnt, cyc, first_cyc, last_cyc;
    bit   fd_exp, pend, prv_stall, prv_l, prv_p;
    logic [7:0] pend_d, prv_d;

    task automatic sb_reset();
        n_acc = 0; n_beat = 0; fd_cnt = 0; fd_exp = 0;
        pend = 0; prv_stall = 0; first_cyc = -1; last_cyc = -1;
    endtask

    task automatic sb_cycle(input bit rnd);
        bit orr, lst;
        int r, w, ph, col, idx;
        @(negedge clk);
        cyc++;
        if (!pend && n_acc < W*H && (!rnd || $urandom_range(0, 3) != 0)) begin
            pend   = 1;
            pend_d = rnd ? 8'($urandom) : 8'(n_acc + 1);
        end
        ifa.in_valid  = pend;
        ifa.in_data   = pend ? pend_d : 8'h00;
        orr           = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ifa.out_ready = orr;
        #1;
        chk("frame_done", ifa.frame_done, fd_exp);
        if (ifa.frame_done) fd_cnt++;
        fd_exp = 0;
        if (prv_stall) begin
            chk("stall_valid", ifa.out_valid, 1);
            chk("stall_data", ifa.out_data, prv_d);
            chk("stall_last", ifa.out_last, prv_l);
            chk("stall_phase", ifa.out_row_phase, prv_p);
        end
        if (ifa.out_valid) begin
            chk("beats_in_frame", n_beat < FB, 1);
            if (n_beat < FB) begin
                r   = n_beat / (4*W);
                w   = n_beat % (4*W);
                ph  = w / (2*W);
                col = (w % (2*W)) / 2;
                lst = ((w % (2*W)) == 2*W - 1);
                idx = r*W + col;
                chk("pixel_accepted", idx < n_acc, 1);
                if (idx < n_acc) chk("data", ifa.out_data, pix[idx]);
                chk("phase", ifa.out_row_phase, ph);
                chk("last", ifa.out_last, lst);
                if (ph == 1) chk("in_ready_repeat", ifa.in_ready, lst && orr && r != H-1);
                if (orr) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                    if (n_beat == FB - 1) fd_exp = 1;
                    n_beat++;
                end
            end
        end
        if (ifa.in_valid && ifa.in_ready) begin
            if (n_acc < W*H) pix[n_acc] = ifa.in_data;
            n_acc++;
            pend = 0;
        end
        prv_stall = ifa.out_valid && !orr;
        prv_d = ifa.out_data;
        prv_l = ifa.out_last;
        prv_p = ifa.out_row_phase;
    endtask

    task automatic run_frame(input bit rnd);
        sb_reset();
        for (int i = 0; i < 20000 && fd_cnt == 0; i++) sb_cycle(rnd);
        for (int i = 0; i < 3; i++) sb_cycle(rnd);
        chk("frame_beats", n_beat, FB);
        chk("frame_done_count", fd_cnt, 1);
        chk("frame_accepts", n_acc, W*H);
        if (!rnd) chk("no_bubble", last_cyc - first_cyc, FB - 1);
        ifa.in_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        ifa.in_valid = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        // 13x13: one pixel with a stall, then drain.
        tv[0]  = '{0, 1, 8'hA5, 1, 0, 8'h00, 1, 0, 0, 0};
        tv[1]  = '{0, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 0, 0};
        tv[2]  = '{0, 0, 8'h00, 1, 1, 8'hA5, 0, 0, 0, 0};
        tv[3]  = '{0, 0, 8'h00, 0, 1, 8'hA5, 0, 0, 0, 0};
        tv[4]  = '{0, 0, 8'h00, 1, 1, 8'hA5, 1, 0, 0, 0};
        tv[5]  = '{0, 0, 8'h00, 1, 0, 8'hA5, 1, 0, 0, 0};
        // 1x1: one pixel gives a full 2x2 frame; valid during replay is ignored.
        tv[6]  = '{1, 1, 8'h3C, 1, 0, 8'h00, 1, 0, 0, 0};
        tv[7]  = '{1, 0, 8'h00, 1, 1, 8'h3C, 0, 0, 0, 0};
        tv[8]  = '{1, 0, 8'h00, 1, 1, 8'h3C, 0, 0, 1, 0};
        tv[9]  = '{1, 1, 8'h77, 1, 1, 8'h3C, 0, 1, 0, 0};
        tv[10] = '{1, 1, 8'h77, 1, 1, 8'h3C, 0, 1, 1, 0};
        tv[11] = '{1, 0, 8'h00, 1, 0, 8'h3C, 1, 0, 0, 1};
        tv[12] = '{1, 0, 8'h00, 1, 0, 8'h3C, 1, 0, 0, 0};

        cyc = 0;
        sb_reset();
        rst_n = 1;
        ifa.in_valid = 0; ifa.in_data = 0; ifa.out_ready = 1;
        ifb.in_valid = 0; ifb.in_data = 0; ifb.out_ready = 1;
        #2 rst_n = 0;
        #1;
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_out_data", ifa.out_data, 0);
        chk("rst_in_ready", ifa.in_ready, 0);
        chk("rst_phase", ifa.out_row_phase, 0);
        chk("rst_last", ifa.out_last, 0);
        chk("rst_frame_done", ifa.frame_done, 0);
        chk("rst_b_out_valid", ifb.out_valid, 0);
        chk("rst_b_in_ready", ifb.in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            ifa.in_valid = 0; ifa.in_data = 0; ifa.out_ready = 1;
            ifb.in_valid = 0; ifb.in_data = 0; ifb.out_ready = 1;
            if (tv[i].sel) begin
                ifb.in_valid = tv[i].iv; ifb.in_data = tv[i].d; ifb.out_ready = tv[i].orr;
            end else begin
                ifa.in_valid = tv[i].iv; ifa.in_data = tv[i].d; ifa.out_ready = tv[i].orr;
            end
            #1;
            if (tv[i].sel) begin
                chk($sformatf("vec%0d_valid", i), ifb.out_valid, tv[i].ov);
                chk($sformatf("vec%0d_data", i), ifb.out_data, tv[i].od);
                chk($sformatf("vec%0d_in_ready", i), ifb.in_ready, tv[i].ir);
                chk($sformatf("vec%0d_phase", i), ifb.out_row_phase, tv[i].ph);
                chk($sformatf("vec%0d_last", i), ifb.out_last, tv[i].lst);
                chk($sformatf("vec%0d_frame_done", i), ifb.frame_done, tv[i].fd);
            end else begin
                chk($sformatf("vec%0d_valid", i), ifa.out_valid, tv[i].ov);
                chk($sformatf("vec%0d_data", i), ifa.out_data, tv[i].od);
                chk($sformatf("vec%0d_in_ready", i), ifa.in_ready, tv[i].ir);
                chk($sformatf("vec%0d_phase", i), ifa.out_row_phase, tv[i].ph);
                chk($sformatf("vec%0d_last", i), ifa.out_last, tv[i].lst);
                chk($sformatf("vec%0d_frame_done", i), ifa.frame_done, tv[i].fd);
            end
        end
        @(negedge clk);
        ifb.in_valid = 0;

        // Ramp 1..169 with continuous output readiness.
        do_reset();
        run_frame(0);

        // Random valid/ready across a whole frame.
        run_frame(1);

        // Reset in the middle of row 5, column 7.
        do_reset();
        sb_reset();
        for (int i = 0; i < 5000 && n_acc < 5*W + 8; i++) sb_cycle(0);
        chk("midrow_reached", n_acc, 5*W + 8);
        @(posedge clk);
        #2;
        rst_n = 0;
        ifa.in_valid = 0;
        #1;
        chk("async_rst_out_valid", ifa.out_valid, 0);
        chk("async_rst_out_data", ifa.out_data, 0);
        chk("async_rst_in_ready", ifa.in_ready, 0);
        chk("async_rst_phase", ifa.out_row_phase, 0);
        chk("async_rst_last", ifa.out_last, 0);
        chk("async_rst_frame_done", ifa.frame_done, 0);
        @(negedge clk);
        rst_n = 1;
        run_frame(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pool_upsample2x.md
Name: pool_upsample2x

Overview:
- 2x nearest-neighbour unpooling stage; the inverse of the 2x2 pooling path.
- Accepts a raster stream of pooled pixels, WIDTH_IN per row and HEIGHT_IN rows per frame.
- Emits each pixel twice horizontally and each row twice vertically, giving 2*WIDTH_IN x 2*HEIGHT_IN.
- A one-row register line buffer replays the second copy of each row; valid/ready on both sides.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- WIDTH_IN, 13, input pixels per row (pooled width of a 26-wide image).
- HEIGHT_IN, 13, input rows per frame.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_WIDTH  pooled pixel.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  DATA_WIDTH  upsampled pixel.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- out_row_phase  output  1  0 = first copy of row (live input), 1 = replayed copy.
- out_last  output  1  high with the final beat of each output row (beat 2*WIDTH_IN-1).
- frame_done  output  1  one-cycle pulse after the last beat of the frame is accepted.

Behaviour:
- Reset (async, rst_n=0): state LIVE, column counters 0, row counter 0, dup 0. Outputs: out_valid 0, out_data 0, in_ready 0, out_row_phase 0, out_last 0, frame_done 0. Line buffer contents are not reset.
- Handshakes: accept = in_valid & in_ready; beat = out_valid & out_ready. While out_valid=1 and out_ready=0, out_data, out_last and out_row_phase hold stable. in_ready may depend combinationally on out_ready; in_valid must never depend on in_ready.
- Output register holds one pixel plus a dup bit (0 = first copy, 1 = second copy). Each output register load produces exactly 2 beats.
- State LIVE (out_row_phase=0):
  - in_ready = (in_cnt < WIDTH_IN) & (!out_valid | (dup & out_ready)).
  - On accept: buf[in_cnt] <= in_data, out_data <= in_data, out_valid <= 1, dup <= 0, in_cnt++. Latency from accept to out_valid is 1 cycle.
  - A beat with dup=0 sets dup <= 1.
  - A beat with dup=1 and no simultaneous accept clears out_valid, unless it is the row's final beat.
  - Sustained throughput: 1 input per 2 cycles.
- LIVE -> REPEAT on the final beat of the row (out column WIDTH_IN-1, dup=1):
  - out_data <= buf[0], dup <= 0, out_valid stays 1, so there is no bubble.
  - in_cnt <= 0, rep_col <= 0.
- State REPEAT (out_row_phase=1):
  - in_ready = 0, except during the final beat: rep_col==WIDTH_IN-1 & dup & out_ready & row not last.
  - A dup=1 beat advances rep_col and loads out_data <= buf[rep_col+1].
- REPEAT final beat:
  - If row < HEIGHT_IN-1: row++, state LIVE. A simultaneous accept loads the new pixel seamlessly; otherwise out_valid <= 0.
  - If row == HEIGHT_IN-1: frame_done pulses the next cycle, row <= 0, state LIVE, out_valid <= 0.
- out_last = out_valid & dup & (column == WIDTH_IN-1), in both states.
- Arithmetic and widths:
  - Counters are $clog2(WIDTH_IN+1) and $clog2(HEIGHT_IN) bits, with exact wrap at the terminal values above. No saturation and no modular overflow paths.
  - out_data is a pure copy; no arithmetic is applied to pixels.
- Boundary rules:
  - WIDTH_IN=1 and HEIGHT_IN=1 are legal.
  - Extra in_valid in REPEAT is ignored; in_ready=0 so nothing is lost.
  - Reset mid-row discards the partial row and frame; the next accept after reset is treated as row 0, column 0.
  - out_ready held low for any duration stalls everything with no data loss or duplication.

Test Plan:
- Reset, then in_valid held with ramp 1..169, out_ready=1 (W=H=13) -> 676 beats. Row 0: 1,1,2,2..13,13 twice, phase 0 then 1. out_last on beats 25 and 51 of each row pair. One frame_done pulse only after beat 676.
- Single pixel 0xA5 then in_valid=0 -> out_valid rises 1 cycle after accept. Two beats of 0xA5, out_valid low, in_ready high again.
- Random out_ready (50%) across a full frame -> output sequence matches the golden model exactly; out_data stable whenever out_valid & !out_ready.
- in_valid held through a REPEAT phase -> in_ready=0 throughout except the final beat. The next row's first pixel is accepted coincident with that beat, with no output bubble.
- Assert rst_n=0 mid-row 5, column 7 -> all outputs 0 asynchronously. A fresh frame afterwards starts at row 0 phase 0, and frame_done fires after exactly 676 beats.
- W=H=1 build, input 0x3C -> 4 beats of 0x3C: phase 0,0,1,1, out_last on beats 2 and 4, then frame_done.
